// File: rtl/snooze_countdown_pkg.sv
// Shared types and constants for the MM:SS down-counter.
package snooze_countdown_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

  localparam int unsigned TENS_MAX  = 5;
  localparam int unsigned UNITS_MAX = 9;
  localparam int unsigned TENS_W    = 3;
  localparam int unsigned UNITS_W   = 4;

  // Clamp a digit value to its legal maximum.
  function automatic int unsigned sat_digit(int unsigned v, int unsigned max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/snooze_countdown_if.sv
// Control, load-value and status bundle of the snooze/countdown timer.
interface snooze_countdown_if;
  import snooze_countdown_pkg::*;

  logic               Tick;
  logic               LD;
  logic [TENS_W-1:0]  IN_MT;
  logic [UNITS_W-1:0] IN_MU;
  logic [TENS_W-1:0]  IN_ST;
  logic [UNITS_W-1:0] IN_SU;
  logic               Start;
  logic               Stop;
  logic               Snooze;
  logic [TENS_W-1:0]  MT;
  logic [UNITS_W-1:0] MU;
  logic [TENS_W-1:0]  ST;
  logic [UNITS_W-1:0] SU;
  logic               Running;
  logic               Expired;
  logic               Done;

  modport master (
    output Tick, LD, IN_MT, IN_MU, IN_ST, IN_SU, Start, Stop, Snooze,
    input  MT, MU, ST, SU, Running, Expired, Done
  );

  modport slave (
    input  Tick, LD, IN_MT, IN_MU, IN_ST, IN_SU, Start, Stop, Snooze,
    output MT, MU, ST, SU, Running, Expired, Done
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit that counts down with borrow, loads with saturation at Max.
module bcd_down_digit #(
  parameter int unsigned Width = 4,
  parameter int unsigned Max   = 9
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             borrow_i,
  output logic             borrow_o,
  output logic [Width-1:0] digit_o
);

  localparam logic [Width-1:0] MaxV = Width'(Max);

  logic [Width-1:0] digit_d, digit_q;

  // Next digit: load (saturated) wins over a borrow-driven decrement.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = (load_val_i > MaxV) ? MaxV : load_val_i;
    end else if (borrow_i) begin
      digit_d = (digit_q == '0) ? MaxV : digit_q - Width'(1);
    end
  end

  // Digit register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clear_i) digit_q <= '0;
    else         digit_q <= digit_d;
  end

  // Borrow ripples onward only when this digit wraps.
  always_comb begin
    borrow_o = borrow_i && (digit_q == '0);
    digit_o  = digit_q;
  end

endmodule

// File: rtl/snooze_countdown.sv
// MM:SS down-counting timer: control FSM, four borrow-chained BCD digits,
// expiry detect and the one-cycle Done pulse.
module snooze_countdown
  import snooze_countdown_pkg::*;
#(
  parameter int unsigned PRESET_MT = 0,
  parameter int unsigned PRESET_MU = 9,
  parameter int unsigned PRESET_ST = 0,
  parameter int unsigned PRESET_SU = 0
) (
  input logic              Clk,
  input logic              Clr,
  snooze_countdown_if.slave bus
);

  localparam int unsigned PresetMt = sat_digit(PRESET_MT, TENS_MAX);
  localparam int unsigned PresetMu = sat_digit(PRESET_MU, UNITS_MAX);
  localparam int unsigned PresetSt = sat_digit(PRESET_ST, TENS_MAX);
  localparam int unsigned PresetSu = sat_digit(PRESET_SU, UNITS_MAX);

  localparam logic [TENS_W-1:0]  PresetMtV = PresetMt[TENS_W-1:0];
  localparam logic [UNITS_W-1:0] PresetMuV = PresetMu[UNITS_W-1:0];
  localparam logic [TENS_W-1:0]  PresetStV = PresetSt[TENS_W-1:0];
  localparam logic [UNITS_W-1:0] PresetSuV = PresetSu[UNITS_W-1:0];

  state_e state_d, state_q;
  logic   done_d, done_q;

  logic               load, dec, start_fire, zero, at_one;
  logic [TENS_W-1:0]  ld_mt, ld_st, mt, st;
  logic [UNITS_W-1:0] ld_mu, ld_su, mu, su;
  logic               su_borrow, st_borrow, mu_borrow, mt_borrow;

  always_comb begin
    zero   = (mt == '0) && (mu == '0) && (st == '0) && (su == '0);
    at_one = (mt == '0) && (mu == '0) && (st == '0) && (su == UNITS_W'(1));
  end

  // Load source and decrement enable, honouring LD > Snooze > Stop > Start > Tick.
  always_comb begin
    load       = bus.LD || bus.Snooze;
    ld_mt      = bus.LD ? bus.IN_MT : PresetMtV;
    ld_mu      = bus.LD ? bus.IN_MU : PresetMuV;
    ld_st      = bus.LD ? bus.IN_ST : PresetStV;
    ld_su      = bus.LD ? bus.IN_SU : PresetSuV;
    start_fire = bus.Start && !zero && (state_q == StIdle || state_q == StPause);
    // Start never blocks a Tick in RUN because start_fire cannot occur there.
    dec        = bus.Tick && (state_q == StRun) && !zero &&
                 !bus.LD && !bus.Snooze && !bus.Stop;
  end

  // Next-state and Done pulse.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (bus.LD) begin
      state_d = StIdle;
    end else if (bus.Snooze) begin
      state_d = StRun;
    end else if (bus.Stop) begin
      if (state_q == StRun)          state_d = StPause;
      else if (state_q == StExpired) state_d = StIdle;
    end else if (start_fire) begin
      state_d = StRun;
    end else if (dec && at_one) begin
      state_d = StExpired;
      done_d  = 1'b1;
    end
  end

  // State and Done registers; Clr also drops any pending Done.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  bcd_down_digit #(.Width(UNITS_W), .Max(UNITS_MAX)) u_su (
    .clk_i      (Clk),
    .clear_i    (Clr),
    .load_i     (load),
    .load_val_i (ld_su),
    .borrow_i   (dec),
    .borrow_o   (su_borrow),
    .digit_o    (su)
  );

  bcd_down_digit #(.Width(TENS_W), .Max(TENS_MAX)) u_st (
    .clk_i      (Clk),
    .clear_i    (Clr),
    .load_i     (load),
    .load_val_i (ld_st),
    .borrow_i   (su_borrow),
    .borrow_o   (st_borrow),
    .digit_o    (st)
  );

  bcd_down_digit #(.Width(UNITS_W), .Max(UNITS_MAX)) u_mu (
    .clk_i      (Clk),
    .clear_i    (Clr),
    .load_i     (load),
    .load_val_i (ld_mu),
    .borrow_i   (st_borrow),
    .borrow_o   (mu_borrow),
    .digit_o    (mu)
  );

  bcd_down_digit #(.Width(TENS_W), .Max(TENS_MAX)) u_mt (
    .clk_i      (Clk),
    .clear_i    (Clr),
    .load_i     (load),
    .load_val_i (ld_mt),
    .borrow_i   (mu_borrow),
    .borrow_o   (mt_borrow),
    .digit_o    (mt)
  );

  // Decrement is gated at 00:00, so the top digit can never underflow.
  mt_no_underflow: assert property (@(posedge Clk) disable iff (Clr) !mt_borrow);

  // Registered status outputs.
  always_comb begin
    bus.MT      = mt;
    bus.MU      = mu;
    bus.ST      = st;
    bus.SU      = su;
    bus.Running = (state_q == StRun);
    bus.Expired = (state_q == StExpired);
    bus.Done    = done_q;
  end

endmodule

// File: doc/snooze_countdown.md
# snooze_countdown

Down-counting MM:SS timer for the alarm clock's snooze and countdown features: the decrementing counterpart of the clock's up-counting digit counters. Loads a BCD minutes:seconds value (or a parameterised snooze preset), counts down one step per one-second strobe with borrow propagation across four digits, and flags expiry to the alarm sequencer. Sits beside the time-keeping counter chain and shares its 1 Hz tick and display digit format.

## Interface
- PRESET_MT, 0, snooze preset minutes tens (0-5)
- PRESET_MU, 9, snooze preset minutes units (0-9)
- PRESET_ST, 0, snooze preset seconds tens (0-5)
- PRESET_SU, 0, snooze preset seconds units (0-9)

- Clk  in  1  system clock; all state changes on rising edge
- Clr  in  1  reset, synchronous, active-high
- Tick  in  1  one-second strobe, one Clk cycle wide
- LD  in  1  load IN_MT/IN_MU/IN_ST/IN_SU into the digits
- IN_MT  in  3  load value, minutes tens
- IN_MU  in  4  load value, minutes units
- IN_ST  in  3  load value, seconds tens
- IN_SU  in  4  load value, seconds units
- Start  in  1  begin or resume counting
- Stop  in  1  pause counting, or acknowledge expiry
- Snooze  in  1  load the PRESET_* value and start immediately
- MT, MU, ST, SU  out  3/4/3/4  current BCD digits
- Running  out  1  high while in RUN
- Expired  out  1  level, high in EXPIRED
- Done  out  1  single-cycle pulse on reaching 00:00

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. Reset: IDLE, all digits 0, Running/Expired/Done 0.
- Per-edge priority: Clr > LD > Snooze > Stop > Start > Tick.
- LD, any state: digits take the load value, state becomes IDLE, Expired cleared. Out-of-range digits saturate: tens >5 loads 5, units >9 loads 9.
- Snooze, any state: digits take the preset, state becomes RUN, Expired cleared.
- Stop: RUN goes to PAUSE; EXPIRED goes to IDLE (alarm acknowledge); IDLE and PAUSE unchanged.
- Start: IDLE or PAUSE goes to RUN if digits are not 00:00; otherwise ignored. Ignored in RUN and EXPIRED.
- Tick, RUN only: decrement SU. SU 0 wraps to 9 with a borrow into ST. ST 0 wraps to 5 with a borrow into MU. MU 0 wraps to 9 with a borrow into MT. Tick is ignored in every other state.
- Expiry: a Tick that moves the digits from 00:01 to 00:00 also moves the state to EXPIRED and sets Done for exactly one cycle. The digits never wrap below 00:00.
- Running = (state == RUN). Expired = (state == EXPIRED).

## Timing
- All outputs are registered; LD, Snooze, Start, Stop and Tick take effect at the same rising edge they are sampled.
- Decrement latency is one cycle: the digits change at the edge where Tick is sampled.
- Done and Expired rise at the edge that writes 00:00. Done falls one cycle later; Expired holds until Stop, LD, Snooze or Clr.
- Start and Tick in the same cycle from IDLE/PAUSE: enter RUN, no decrement.
- Stop and Tick in the same cycle in RUN: enter PAUSE, no decrement.
- Start and Stop in the same cycle: Stop wins.
- Clr mid-count: next edge gives IDLE and 00:00, and any pending Done is suppressed.
- Maximum count is 59:59; a full countdown takes 3599 Ticks.

## Structure
- Shared package contains:
  - state enum (IDLE, RUN, PAUSE, EXPIRED)
  - digit limit constants TENS_MAX=5, UNITS_MAX=9
  - BCD digit widths
- Sub-module `bcd_down_digit`, parameterised by MAX, instantiated four times:
  - inputs: load, load value, borrow_in, clear
  - output: borrow_out, asserted when the digit is 0 and borrow_in is high
  - saturates load values above MAX
- Top level holds the FSM, the expiry detect (all digits 0 after a decrement) and the Done register.

## Test plan
- Reset then LD 00:03, Start, 3 Ticks: digits 00:02, 00:01, 00:00; Done high one cycle; Expired=1; Running=0.
- LD 10:00, Start, 1 Tick: digits 09:59 (full borrow chain); 2nd Tick gives 09:58.
- LD 07:5C (SU=12): SU saturates to 9, reads 07:59; Start at 00:00 after LD 00:00 is ignored (state stays IDLE).
- RUN at 01:30, Stop together with Tick: PAUSE, digits stay 01:30; Ticks in PAUSE leave 01:30; Start plus Tick gives RUN and 01:30; the next Tick gives 01:29.
- From EXPIRED, Snooze: digits 09:00, Running=1, Expired=0; alternatively Stop gives IDLE with Expired=0.
- RUN at 00:01, Clr in the same cycle as Tick: 00:00, IDLE, Done stays 0 throughout.
